// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, address/data widths, acknowledge counts per mode.
package i2c_pkg;

   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;

   // Acknowledge phases to wait for before closing a transaction:
   // write = address + data byte, read = address + returned byte.
   localparam int WR_ACKS = 2;
   localparam int RD_ACKS = 2;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      START,
      WAIT,
      CLOSE,
      DONE,
      ERR
   } state_t;

   function automatic int acks_needed(input logic rd);
      return rd ? RD_ACKS : WR_ACKS;
   endfunction

endpackage

// File: rtl/i2c_rr_arb.sv
// Two-way round-robin arbiter; the requester served last gets lowest priority.
// Latency: grant is combinational from req; pointer updates on the take edge.
// Backpressure: grant is only consumed when take is high; otherwise it just tracks req.
// Ports: clk, reset (sync, active-low), req[1:0], take, gnt_vld, gnt_id.
module i2c_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       take,
   output logic       gnt_vld,
   output logic       gnt_id
);

   // ptr names the requester that currently holds priority.
   logic ptr;

   always_comb begin
      gnt_vld = |req;
      gnt_id  = req[ptr] ? ptr : ~ptr;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= 1'b0;
      end else if (take && gnt_vld) begin
         ptr <= ~gnt_id;
      end
   end

endmodule

// File: rtl/i2c_txn_sched.sv
// Schedules single-byte I2C transactions from two requesters onto one master.
// Latency: grant 1 cycle after req, m_start 2 cycles after req; done 2 cycles after the 2nd ack.
// Backpressure: requesters wait in IDLE while busy; master paces progress via m_ack pulses.
// Ports: req/addr/reg/rd per requester in, done/err per requester out, rdata, busy,
//        m_* master control out, m_out/m_ack from master.
// Option: define I2C_SCHED_TIMEOUT_EN to enable the per-transaction watchdog (ERR path).
module i2c_txn_sched
   import i2c_pkg::*;
#(
   parameter int TO_CYCLES = 4096,
   parameter int ACK_W     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] reg0,
   input  logic [DATA_W-1:0] reg1,
   input  logic              rd0,
   input  logic              rd1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] m_address,
   output logic [DATA_W-1:0] m_register,
   output logic              m_mode,
   output logic              m_en,
   output logic              m_start,
   output logic              m_stop,
   output logic              m_repeat_start,
   input  logic [DATA_W-1:0] m_out,
   input  logic              m_ack,
   output logic              busy
);

   state_t             state_q, state_d;
   logic               gnt_q;
   logic [ACK_W-1:0]   ack_cnt;
   logic               ack_q;
   logic               ack_rise;
   logic               last_ack;
   logic               to_hit;
   logic               gnt_vld, gnt_id;

   i2c_rr_arb u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({req1, req0}),
      .take    (state_q == IDLE),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   // The master's ack may be wider than one cycle; only count its leading edge.
   assign ack_rise = m_ack & ~ack_q;
   assign last_ack = (ack_cnt == ACK_W'(acks_needed(m_mode) - 1));

`ifdef I2C_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
   logic            err_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_q inside {START, WAIT, CLOSE}) to_cnt <= to_cnt + 1'b1;
         else                                     to_cnt <= '0;
         if (state_q == ERR)       err_q <= 1'b1;
         else if (state_q == IDLE) err_q <= 1'b0;
      end
   end

   assign to_hit = (state_q inside {START, WAIT, CLOSE}) && (to_cnt == TO_W'(TO_CYCLES - 1));
   assign err0   = done0 & err_q;
   assign err1   = done1 & err_q;
`else
   assign to_hit = 1'b0;
   assign err0   = 1'b0;
   assign err1   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         m_address  <= '0;
         m_register <= '0;
         m_mode     <= 1'b0;
         ack_cnt    <= '0;
         ack_q      <= 1'b0;
         rdata      <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= m_ack;
         case (state_q)
            IDLE:  if (gnt_vld) gnt_q <= gnt_id;
            GRANT: begin
               m_address  <= gnt_q ? addr1 : addr0;
               m_register <= gnt_q ? reg1  : reg0;
               m_mode     <= gnt_q ? rd1   : rd0;
            end
            START: ack_cnt <= '0;
            WAIT:  if (ack_rise) ack_cnt <= ack_cnt + 1'b1;
            CLOSE: if (m_mode && !to_hit) rdata <= m_out;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (gnt_vld) state_d = GRANT;
         GRANT: state_d = START;
         START: state_d = to_hit ? ERR : WAIT;
         WAIT: begin
            if (to_hit)                    state_d = ERR;
            else if (ack_rise && last_ack) state_d = CLOSE;
         end
         CLOSE: state_d = to_hit ? ERR : DONE;
         DONE:  state_d = IDLE;
         ERR:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_en           = 1'b0;
      m_start        = 1'b0;
      m_stop         = 1'b0;
      m_repeat_start = 1'b0;
      done0          = 1'b0;
      done1          = 1'b0;
      busy           = (state_q != IDLE);
      case (state_q)
         START: begin
            m_en    = 1'b1;
            m_start = 1'b1;
            m_stop  = m_mode;
         end
         WAIT: begin
            m_en   = 1'b1;
            m_stop = m_mode;
         end
         // Read keeps stop held through here; a write gets its single stop cycle here.
         CLOSE: begin
            m_en   = 1'b1;
            m_stop = 1'b1;
         end
         ERR:  m_stop = 1'b1;
         DONE: begin
            done0 = ~gnt_q;
            done1 = gnt_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Directed self-checking bench for i2c_txn_sched.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_txn_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, rd0, rd1, m_ack;
   logic [6:0] addr0, addr1;
   logic [7:0] reg0, reg1, m_out;
   logic       done0, done1, err0, err1, busy;
   logic [7:0] rdata, m_register;
   logic [6:0] m_address;
   logic       m_mode, m_en, m_start, m_stop, m_repeat_start;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   i2c_txn_sched #(.TO_CYCLES(16), .ACK_W(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .req0           (req0),
      .req1           (req1),
      .addr0          (addr0),
      .addr1          (addr1),
      .reg0           (reg0),
      .reg1           (reg1),
      .rd0            (rd0),
      .rd1            (rd1),
      .done0          (done0),
      .done1          (done1),
      .err0           (err0),
      .err1           (err1),
      .rdata          (rdata),
      .m_address      (m_address),
      .m_register     (m_register),
      .m_mode         (m_mode),
      .m_en           (m_en),
      .m_start        (m_start),
      .m_stop         (m_stop),
      .m_repeat_start (m_repeat_start),
      .m_out          (m_out),
      .m_ack          (m_ack),
      .busy           (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Steps until m_start is seen, giving up after a fixed cycle budget.
   task automatic wait_start(input string tag);
      int n = 0;
      while (m_start !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_start"}, {31'd0, m_start}, 32'd1);
   endtask

   // Entered in START; leaves the DUT in CLOSE after the 2nd ack edge.
   task automatic send_acks();
      step();
      chk("start_one_cycle", {31'd0, m_start}, 32'd0);
      m_ack = 1'b1; step();
      m_ack = 1'b0; step();
      m_ack = 1'b1; step();
      m_ack = 1'b0;
   endtask

   initial begin
      int  n;
      bit  seen;

      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; rd0 = 1'b0; rd1 = 1'b0; m_ack = 1'b0;
      addr0 = '0; addr1 = '0; reg0 = '0; reg1 = '0; m_out = '0;
      repeat (3) step();

      chk("rst_busy",   {31'd0, busy},  32'd0);
      chk("rst_en",     {31'd0, m_en},  32'd0);
      chk("rst_stop",   {31'd0, m_stop}, 32'd0);
      chk("rst_rdata",  {24'd0, rdata}, 32'd0);
      chk("rst_done",   {30'd0, done1, done0}, 32'd0);
      chk("rst_rstart", {31'd0, m_repeat_start}, 32'd0);
      reset = 1'b1;
      step();

      // Write from requester 0; req dropped after START must not abort it.
      req0 = 1'b1; addr0 = 7'h50; reg0 = 8'hA5; rd0 = 1'b0;
      wait_start("wr");
      chk("wr_en",   {31'd0, m_en},    32'd1);
      chk("wr_addr", {25'd0, m_address}, 32'h50);
      chk("wr_reg",  {24'd0, m_register}, 32'hA5);
      chk("wr_mode", {31'd0, m_mode},  32'd0);
      chk("wr_nostop_start", {31'd0, m_stop}, 32'd0);
      chk("wr_busy", {31'd0, busy},    32'd1);
      req0 = 1'b0;
      send_acks();
      chk("wr_stop_close", {31'd0, m_stop}, 32'd1);
      step();
      chk("wr_done", {30'd0, done1, done0}, 32'd1);
      chk("wr_err",  {30'd0, err1, err0},   32'd0);
      chk("wr_stop_one", {31'd0, m_stop},   32'd0);
      step();
      chk("wr_done_pulse", {31'd0, done0}, 32'd0);
      chk("wr_idle", {31'd0, busy},  32'd0);

      // Read from requester 1.
      req1 = 1'b1; addr1 = 7'h1E; rd1 = 1'b1; m_out = 8'h3C;
      wait_start("rd");
      chk("rd_mode", {31'd0, m_mode}, 32'd1);
      chk("rd_stop_start", {31'd0, m_stop}, 32'd1);
      chk("rd_addr", {25'd0, m_address}, 32'h1E);
      req1 = 1'b0;
      send_acks();
      chk("rd_stop_close", {31'd0, m_stop}, 32'd1);
      step();
      chk("rd_rdata", {24'd0, rdata}, 32'h3C);
      chk("rd_done",  {30'd0, done1, done0}, 32'd2);
      chk("rd_err",   {30'd0, err1, err0},   32'd0);
      step();

      // Contention: both held; requester 1 was served last so order is 0,1,0,1.
      addr0 = 7'h11; addr1 = 7'h22; rd0 = 1'b0; rd1 = 1'b0; m_out = 8'hFF;
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_start("ct");
         chk("ct_addr", {25'd0, m_address}, (i % 2) ? 32'h22 : 32'h11);
         send_acks();
         step();
         chk("ct_winner", {30'd0, done1, done0}, (i % 2) ? 32'd2 : 32'd1);
         if (i == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      step();
      chk("ct_idle", {31'd0, busy}, 32'd0);
      chk("rdata_hold", {24'd0, rdata}, 32'h3C);

`ifdef I2C_SCHED_TIMEOUT_EN
      // Watchdog: no acks at all.
      req0 = 1'b1; rd0 = 1'b0;
      wait_start("to");
      req0 = 1'b0;
      n = 0;
      seen = 1'b0;
      while (done0 !== 1'b1 && n < 40) begin
         step();
         n++;
         if (m_stop === 1'b1 && done0 !== 1'b1) seen = 1'b1;
      end
      chk("to_done", {31'd0, done0}, 32'd1);
      chk("to_err",  {31'd0, err0},  32'd1);
      chk("to_stop_seen", {31'd0, seen}, 32'd1);
      chk("to_latency_in_window", {31'd0, (n >= 14 && n <= 18)}, 32'd1);
      step();
      chk("to_idle", {31'd0, busy}, 32'd0);
`endif

      // Reset in the middle of WAIT.
      req0 = 1'b1; addr0 = 7'h50; rd0 = 1'b0;
      wait_start("rst");
      req0 = 1'b0;
      step();
      m_ack = 1'b1; step();
      m_ack = 1'b0;
      reset = 1'b0;
      step();
      chk("mid_busy",  {31'd0, busy},    32'd0);
      chk("mid_ctl",   {29'd0, m_en, m_start, m_stop}, 32'd0);
      chk("mid_addr",  {25'd0, m_address}, 32'd0);
      chk("mid_reg",   {24'd0, m_register}, 32'd0);
      chk("mid_mode",  {31'd0, m_mode},  32'd0);
      chk("mid_rdata", {24'd0, rdata},   32'd0);
      reset = 1'b1;
      seen = (done0 === 1'b1) || (done1 === 1'b1);
      for (int i = 0; i < 6; i++) begin
         step();
         if (done0 === 1'b1 || done1 === 1'b1) seen = 1'b1;
      end
      chk("mid_no_done", {31'd0, seen}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
